// File: rtl/mult_arb_pkg.sv
// Shared types and widths for the two-requester multiplier arbiter.
package mult_arb_pkg;

    localparam int unsigned OP_W   = 4;
    localparam int unsigned PROD_W = 8;
    localparam int unsigned ID_W   = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/array_mult4.sv
// Combinational 4x4 unsigned array multiplier built from rows of full adders.
module array_mult4
    import mult_arb_pkg::*;
(
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [PROD_W-1:0] product
);

    logic [PROD_W-1:0] acc;
    logic [PROD_W-1:0] addend;
    logic [PROD_W-1:0] sum;
    logic              carry;

    // Each row adds one shifted partial product into the running sum
    // through a ripple chain of full adders.
    always_comb begin
        acc    = '0;
        addend = '0;
        sum    = '0;
        carry  = 1'b0;
        for (int unsigned i = 0; i < OP_W; i++) begin
            addend = '0;
            for (int unsigned j = 0; j < OP_W; j++) begin
                addend[i+j] = a[j] & b[i];
            end
            carry = 1'b0;
            for (int unsigned k = 0; k < PROD_W; k++) begin
                sum[k] = acc[k] ^ addend[k] ^ carry;
                carry  = (acc[k] & addend[k]) | (carry & (acc[k] ^ addend[k]));
            end
            acc = sum;
        end
        product = acc;
    end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter feeding a shared 4x4 multiplier with a ready/valid result port.
// Optional MULT_ARBITER_ZERO_SKIP_EN: zero operands bypass the CALC state.
module mult_arbiter
    import mult_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [OP_W-1:0]   req0_a,
    input  logic [OP_W-1:0]   req0_b,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [OP_W-1:0]   req1_a,
    input  logic [OP_W-1:0]   req1_b,
    output logic              req1_ready,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [PROD_W-1:0] res_product,
    output logic [ID_W-1:0]   res_id,
    output logic              busy
);

    state_t            state;
    state_t            state_nxt;
    logic [ID_W-1:0]   last_id;
    logic [ID_W-1:0]   grant_id;
    logic              accept;
    logic [OP_W-1:0]   op_a;
    logic [OP_W-1:0]   op_b;
    logic [OP_W-1:0]   sel_a;
    logic [OP_W-1:0]   sel_b;
    logic [PROD_W-1:0] prod_comb;
`ifdef MULT_ARBITER_ZERO_SKIP_EN
    logic              zero_op;
`endif

    array_mult4 u_mult (
        .a       (op_a),
        .b       (op_b),
        .product (prod_comb)
    );

    always_comb begin
        grant_id   = '0;
        accept     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        sel_a      = req0_a;
        sel_b      = req0_b;
        state_nxt  = state;

        // Contention goes to whoever was not served last; otherwise the lone valid wins.
        if (req0_valid && req1_valid) begin
            grant_id = ~last_id;
        end else begin
            grant_id = req1_valid;
        end

        if (grant_id != '0) begin
            sel_a = req1_a;
            sel_b = req1_b;
        end

        accept     = (state == ST_IDLE) && !rst && (req0_valid || req1_valid);
        req0_ready = accept && (grant_id == '0);
        req1_ready = accept && (grant_id != '0);

`ifdef MULT_ARBITER_ZERO_SKIP_EN
        zero_op = (sel_a == '0) || (sel_b == '0);
`endif

        case (state)
            ST_IDLE: begin
                if (accept) begin
`ifdef MULT_ARBITER_ZERO_SKIP_EN
                    state_nxt = zero_op ? ST_DONE : ST_CALC;
`else
                    state_nxt = ST_CALC;
`endif
                end
            end
            ST_CALC: state_nxt = ST_DONE;
            ST_DONE: begin
                if (res_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            last_id     <= '1;
            res_id      <= '0;
            res_product <= '0;
            op_a        <= '0;
            op_b        <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_a    <= sel_a;
                op_b    <= sel_b;
                last_id <= grant_id;
                res_id  <= grant_id;
`ifdef MULT_ARBITER_ZERO_SKIP_EN
                if (zero_op) begin
                    res_product <= '0;
                end
`endif
            end
            if (state == ST_CALC) begin
                res_product <= prod_comb;
            end
        end
    end

    assign res_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter against a transaction-level reference model.
module tb_mult_arbiter;

    logic       clk;
    logic       rst;
    logic       req0_valid, req1_valid;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic       req0_ready, req1_ready;
    logic       res_valid, res_ready;
    logic [7:0] res_product;
    logic       res_id;
    logic       busy;

    mult_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_ready  (req1_ready),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_product (res_product),
        .res_id      (res_id),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef MULT_ARBITER_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model: one outstanding job, cycles left until its result shows.
    bit m_init = 1'b0;
    bit m_out  = 1'b0;
    bit m_last = 1'b1;
    bit m_id   = 1'b0;
    int m_wait = 0;
    int m_a    = 0;
    int m_b    = 0;

    logic       o_valid;
    logic       o_id;
    logic [7:0] o_prod;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cycle(input bit r, input bit v0, input int a0, input int b0,
                         input bit v1, input int a1, input int b1, input bit rr);
        bit win;
        bit exp_v;
        bit any;
        rst        = r;
        req0_valid = v0;
        req0_a     = a0[3:0];
        req0_b     = b0[3:0];
        req1_valid = v1;
        req1_a     = a1[3:0];
        req1_b     = b1[3:0];
        res_ready  = rr;
        @(negedge clk);
        o_valid = res_valid;
        o_prod  = res_product;
        o_id    = res_id;
        any   = v0 || v1;
        win   = (v0 && v1) ? !m_last : v1;
        exp_v = m_out && (m_wait == 0);
        if (m_init) begin
            check("req0_ready", req0_ready, !r && !m_out && any && !win);
            check("req1_ready", req1_ready, !r && !m_out && any && win);
            check("busy", busy, m_out);
            check("res_valid", res_valid, exp_v);
            if (exp_v) begin
                check("res_product", res_product, m_a * m_b);
                check("res_id", res_id, m_id);
            end
        end
        @(posedge clk);
        if (r) begin
            m_init = 1'b1;
            m_out  = 1'b0;
            m_last = 1'b1;
        end else if (!m_out) begin
            if (any) begin
                m_id   = win;
                m_a    = win ? (a1 & 15) : (a0 & 15);
                m_b    = win ? (b1 & 15) : (b0 & 15);
                m_out  = 1'b1;
                m_wait = (SKIP && (m_a == 0 || m_b == 0)) ? 0 : 1;
                m_last = win;
            end
        end else if (m_wait > 0) begin
            m_wait--;
        end else if (rr) begin
            m_out = 1'b0;
        end
        #1;
    endtask

    task automatic idle(input bit rr);
        cycle(1'b0, 1'b0, 0, 0, 1'b0, 0, 0, rr);
    endtask

    int ids[$];
    int prods[$];

    initial begin
        cycle(1'b1, 1'b1, 3, 3, 1'b1, 4, 4, 1'b1);
        cycle(1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 1'b1);
        idle(1'b1);
        check("rst_product", o_prod, 0);
        check("rst_id", o_id, 0);
        check("rst_valid", o_valid, 0);

        // single requester, 3x5
        cycle(1'b0, 1'b1, 3, 5, 1'b0, 0, 0, 1'b1);
        idle(1'b1);
        check("lat_calc", o_valid, 0);
        idle(1'b1);
        check("lat_done", o_valid, 1);
        check("p3x5", o_prod, 15);
        check("id3x5", o_id, 0);
        idle(1'b1);

        // zero operand latency
        cycle(1'b0, 1'b1, 0, 9, 1'b0, 0, 0, 1'b1);
        idle(1'b1);
        check("zero_lat1", o_valid, SKIP);
        idle(1'b1);
        check("zero_lat2", o_valid, !SKIP);
        if (o_valid) check("zero_prod", o_prod, 0);
        repeat (2) idle(1'b1);

        // stall in DONE with requests pending
        cycle(1'b0, 1'b0, 0, 0, 1'b1, 2, 3, 1'b0);
        repeat (7) cycle(1'b0, 1'b1, 5, 5, 1'b1, 6, 6, 1'b0);
        check("stall_prod", o_prod, 6);
        check("stall_busy", busy, 1);
        repeat (3) idle(1'b1);

        // reset while in CALC discards the job
        cycle(1'b0, 1'b1, 4, 4, 1'b0, 0, 0, 1'b1);
        cycle(1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 1'b1);
        idle(1'b1);
        check("abort_valid", o_valid, 0);
        check("abort_busy", busy, 0);
        repeat (4) idle(1'b1);

        // contention after reset: round robin 0,1,0,1
        cycle(1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 1'b1);
        ids.delete();
        prods.delete();
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 1'b1, 7, 9, 1'b1, 15, 15, 1'b1);
            if (o_valid) begin
                ids.push_back(int'(o_id));
                prods.push_back(int'(o_prod));
            end
        end
        check("rr_count", ids.size(), 4);
        for (int i = 0; i < ids.size() && i < 4; i++) begin
            check("rr_id", ids[i], i % 2);
            check("rr_prod", prods[i], (i % 2 == 0) ? 63 : 225);
        end
        repeat (3) idle(1'b1);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            cycle(($urandom_range(0, 59) == 0),
                  1'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  1'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) != 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 The block SHALL have exactly one clock and one reset; the reset is synchronous and active-high.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 req0_valid  in  1  requester 0 has an operand pair pending.
REQ-005 req0_a, req0_b  in  4 each  requester 0 unsigned operands.
REQ-006 req0_ready  out  1  requester 0 transfer accepted this cycle when req0_valid is also 1.
REQ-007 req1_valid, req1_a[3:0], req1_b[3:0], req1_ready  SHALL mirror REQ-004..006 for requester 1.
REQ-008 res_valid  out  1  result available.
REQ-009 res_ready  in  1  consumer accepts the result.
REQ-010 res_product  out  8  unsigned product a*b.
REQ-011 res_id  out  1  requester index that owns res_product.
REQ-012 busy  out  1  high whenever the state is not IDLE.

Function
REQ-013 States SHALL be IDLE, CALC and DONE.
REQ-014 In IDLE, exactly one of req0_ready/req1_ready SHALL be high when at least one valid is high, and both SHALL be low otherwise; outside IDLE both readys SHALL be 0.
REQ-015 Grant: if only one valid is high, that requester wins; if both are high, the requester not in last_id wins (round robin).
REQ-016 On a handshake in IDLE, the block SHALL register the operands and the winner index into last_id and res_id, then go to CALC.
REQ-017 In CALC, the block SHALL register the 8-bit product of the held operands into res_product, then go to DONE; the product is exact with no truncation (max 15*15=225).
REQ-018 In DONE, res_valid SHALL be 1 and res_product/res_id SHALL be held stable until res_valid && res_ready, then the block goes to IDLE.
REQ-019 A new request is not accepted in the same cycle a result is consumed; the minimum spacing between accepts is 3 cycles.
REQ-020 Latency: res_valid SHALL assert 2 cycles after the accepting edge (1 cycle with the REQ-026 fast path).
REQ-021 A deasserted valid in IDLE SHALL NOT change last_id.
REQ-022 res_ready asserted while res_valid is 0 SHALL be ignored.

Reset
REQ-023 While rst is high at a clock edge: state is IDLE, res_valid=0, res_product=0, res_id=0, last_id=1 (requester 0 wins the first contention), readys=0, busy=0.
REQ-024 Reset asserted in CALC or DONE SHALL discard the in-flight transaction; no result for it is ever presented.
REQ-025 Reset SHALL override any handshake in the same cycle.

Configuration
REQ-026 Macro MULT_ARBITER_ZERO_SKIP_EN: when defined, an accepted pair with a==0 or b==0 SHALL go directly from IDLE to DONE with res_product=0; when undefined, every transaction passes through CALC.

Structure
REQ-027 Package mult_arb_pkg SHALL hold the state enum and the constants OP_W=4, PROD_W=8 and ID_W=1.
REQ-028 The multiply SHALL be the combinational sub-module array_mult4, a 4x4 unsigned full-adder array with an 8-bit output; the sub-module holds no state.

Verification
REQ-029 req0 a=3, b=5 alone -> req0_ready=1 in IDLE; res_valid 2 cycles later with product=15, id=0.
REQ-030 Both valid after reset, req0 7x9 and req1 15x15 -> req0 served first (63, id 0), then req1 (225, id 1).
REQ-031 Both valid continuously for 4 transactions -> res_id sequence is 0,1,0,1.
REQ-032 res_ready held at 0 for 5 cycles in DONE -> result stable, both readys 0, busy=1.
REQ-033 rst pulsed in CALC -> next cycle in IDLE, res_valid=0, and no result appears for the aborted pair.
REQ-034 a=0, b=9 -> product 0 after 1 cycle with MULT_ARBITER_ZERO_SKIP_EN defined, after 2 cycles without it.
